// File: rtl/soc_pkg.sv
// soc_pkg: shared types and helpers for the SoC memory/IO bus arbiter.
//   ArbState   - arbiter FSM state encoding
//   MemReq     - one captured master request (address, data, mask, read flag)
//   M_CPU/M_AUX - master indices (m0 = CPU, m1 = secondary master)
//   pick_winner - arbitration decision for one ArbIdle cycle
package soc_pkg;

  localparam int M_CPU      = 0;
  localparam int M_AUX      = 1;
  // Captured addresses are stored at full 32-bit width; bits above the
  // arbiter's ADDR_WIDTH are always zero.
  localparam int REQ_ADDR_W = 32;

  typedef enum logic {
    ArbIdle = 1'b0,
    ArbWait = 1'b1
  } ArbState;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            wmask;
    logic                  is_read;
  } MemReq;

  // Returns the master index (0 or 1) to grant. Only meaningful when at
  // least one pend bit is set. In round-robin mode a tie goes to the master
  // that did not win last time.
  function automatic logic pick_winner(input logic pend0,
                                       input logic pend1,
                                       input logic fixed_prio,
                                       input logic last_grant);
    logic win;
    if (pend0 && pend1) begin
      win = fixed_prio ? 1'b0 : ~last_grant;
    end else if (pend1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_req_capture.sv
// mem_req_capture: holds one master's outstanding request until the arbiter
// completes it, and produces that master's registered busy flags.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   addr, wdata, wmask,   master request inputs (one-cycle strobe)
//   rstrb
//   clear                 arbiter completion pulse; drops pend and busy
//   req                   captured request
//   pend                  a request is outstanding
//   rbusy, wbusy          registered busy flags for the master
module mem_req_capture
  import soc_pkg::*;
#(
  parameter int ADDR_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wmask,
  input  logic                  rstrb,
  input  logic                  clear,
  output MemReq                 req,
  output logic                  pend,
  output logic                  rbusy,
  output logic                  wbusy
);

  logic strobe_s;

  assign strobe_s = rstrb | (|wmask);

  // Request capture, pend bit and busy flags. A strobe while a request is
  // already pending is ignored; read wins over write when both are given.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req   <= '0;
      pend  <= 1'b0;
      rbusy <= 1'b0;
      wbusy <= 1'b0;
    end else if (clear) begin
      pend  <= 1'b0;
      rbusy <= 1'b0;
      wbusy <= 1'b0;
    end else if (strobe_s && !pend) begin
      req.addr    <= REQ_ADDR_W'(addr);
      req.wdata   <= wdata;
      req.wmask   <= rstrb ? 4'b0000 : wmask;
      req.is_read <= rstrb;
      pend        <= 1'b1;
      rbusy       <= rstrb;
      wbusy       <= ~rstrb;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory/IO slave bus between two FemtoRV-style
// masters (m0 = CPU, m1 = DMA/loader). One access is in flight at a time.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   mN_addr/wdata/wmask/rstrb     master N request (N = 0,1)
//   mN_rdata                      master N registered read data
//   mN_rbusy/mN_wbusy             master N read/write pending or in service
//   s_addr/s_wdata                slave address and write data
//   s_wmask/s_rstrb               slave one-cycle write/read strobes
//   s_rdata/s_rbusy/s_wbusy       slave read data and busy flags
module mem_bus_arbiter
  import soc_pkg::*;
#(
  parameter int ADDR_WIDTH     = 24,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wmask,
  input  logic                  m0_rstrb,
  output logic [31:0]           m0_rdata,
  output logic                  m0_rbusy,
  output logic                  m0_wbusy,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wmask,
  input  logic                  m1_rstrb,
  output logic [31:0]           m1_rdata,
  output logic                  m1_rbusy,
  output logic                  m1_wbusy,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_wmask,
  output logic                  s_rstrb,
  input  logic [31:0]           s_rdata,
  input  logic                  s_rbusy,
  input  logic                  s_wbusy
);

  MemReq   req0_s, req1_s, sel_s;
  logic    pend0_s, pend1_s;
  logic    clear0_s, clear1_s;
  logic    load0_s, load1_s;
  logic    win_s;
  ArbState state_r, state_n;
  logic    grant_r, grant_n;
  logic    last_grant_r, last_grant_n;
  logic    unused_addr_hi_s;

  // Captured address bits above ADDR_WIDTH are always zero.
  assign unused_addr_hi_s = ^sel_s.addr;

  mem_req_capture #(.ADDR_WIDTH(ADDR_WIDTH)) u_cap0 (
    .clk   (clk),
    .reset (reset),
    .addr  (m0_addr),
    .wdata (m0_wdata),
    .wmask (m0_wmask),
    .rstrb (m0_rstrb),
    .clear (clear0_s),
    .req   (req0_s),
    .pend  (pend0_s),
    .rbusy (m0_rbusy),
    .wbusy (m0_wbusy)
  );

  mem_req_capture #(.ADDR_WIDTH(ADDR_WIDTH)) u_cap1 (
    .clk   (clk),
    .reset (reset),
    .addr  (m1_addr),
    .wdata (m1_wdata),
    .wmask (m1_wmask),
    .rstrb (m1_rstrb),
    .clear (clear1_s),
    .req   (req1_s),
    .pend  (pend1_s),
    .rbusy (m1_rbusy),
    .wbusy (m1_wbusy)
  );

  // Arbiter next state and slave bus drive. The slave strobe is issued in
  // the same ArbIdle cycle the winner is chosen, so it is combinational.
  always_comb begin
    state_n      = state_r;
    grant_n      = grant_r;
    last_grant_n = last_grant_r;
    win_s        = 1'b0;
    sel_s        = req0_s;
    s_addr       = '0;
    s_wdata      = 32'h0000_0000;
    s_wmask      = 4'b0000;
    s_rstrb      = 1'b0;
    clear0_s     = 1'b0;
    clear1_s     = 1'b0;
    load0_s      = 1'b0;
    load1_s      = 1'b0;
    case (state_r)
      ArbIdle: begin
        if (pend0_s || pend1_s) begin
          win_s   = pick_winner(pend0_s, pend1_s, FIXED_PRIORITY != 0, last_grant_r);
          sel_s   = win_s ? req1_s : req0_s;
          s_addr  = sel_s.addr[ADDR_WIDTH-1:0];
          s_wdata = sel_s.wdata;
          if (sel_s.is_read) begin
            s_rstrb = 1'b1;
          end else begin
            s_wmask = sel_s.wmask;
          end
          grant_n      = win_s;
          last_grant_n = win_s;
          state_n      = ArbWait;
        end else begin
          state_n = ArbIdle;
        end
      end
      ArbWait: begin
        sel_s   = grant_r ? req1_s : req0_s;
        s_addr  = sel_s.addr[ADDR_WIDTH-1:0];
        s_wdata = sel_s.wdata;
        if (sel_s.is_read ? !s_rbusy : !s_wbusy) begin
          clear0_s = ~grant_r;
          clear1_s = grant_r;
          load0_s  = sel_s.is_read & ~grant_r;
          load1_s  = sel_s.is_read & grant_r;
          state_n  = ArbIdle;
        end else begin
          state_n = ArbWait;
        end
      end
      default: begin
        state_n = ArbIdle;
      end
    endcase
  end

  // FSM state and grant registers; last_grant resets so m0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ArbIdle;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
    end else begin
      state_r      <= state_n;
      grant_r      <= grant_n;
      last_grant_r <= last_grant_n;
    end
  end

  // Read data registers; each holds until its master's next read completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rdata <= 32'h0000_0000;
      m1_rdata <= 32'h0000_0000;
    end else begin
      if (load0_s) begin
        m0_rdata <= s_rdata;
      end
      if (load1_s) begin
        m1_rdata <= s_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter. Inputs are driven and outputs are
// sampled on the falling clock edge. A second instance runs with fixed priority.
module tb_mem_bus_arbiter;

  localparam int AW = 24;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // round-robin instance signals
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [31:0]   m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic [3:0]    m0_wmask, m1_wmask, s_wmask;
  logic          m0_rstrb, m1_rstrb, s_rstrb;
  logic          m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy, s_rbusy, s_wbusy;

  // fixed-priority instance signals
  logic [AW-1:0] f_m0_addr, f_m1_addr, f_s_addr;
  logic [31:0]   f_m0_wdata, f_m1_wdata, f_m0_rdata, f_m1_rdata, f_s_wdata, f_s_rdata;
  logic [3:0]    f_m0_wmask, f_m1_wmask, f_s_wmask;
  logic          f_m0_rstrb, f_m1_rstrb, f_s_rstrb;
  logic          f_m0_rbusy, f_m0_wbusy, f_m1_rbusy, f_m1_wbusy, f_s_rbusy, f_s_wbusy;

  // slave models: read data is a fixed function of the address
  assign s_rdata   = (s_addr == 24'h000100) ? 32'hDEAD_BEEF : {8'h5A, s_addr};
  assign f_s_rdata = {8'hC0, f_s_addr};
  assign f_s_rbusy = 1'b0;
  assign f_s_wbusy = 1'b0;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIORITY(0)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rstrb(s_rstrb),
    .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy)
  );

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_addr(f_m0_addr), .m0_wdata(f_m0_wdata), .m0_wmask(f_m0_wmask), .m0_rstrb(f_m0_rstrb),
    .m0_rdata(f_m0_rdata), .m0_rbusy(f_m0_rbusy), .m0_wbusy(f_m0_wbusy),
    .m1_addr(f_m1_addr), .m1_wdata(f_m1_wdata), .m1_wmask(f_m1_wmask), .m1_rstrb(f_m1_rstrb),
    .m1_rdata(f_m1_rdata), .m1_rbusy(f_m1_rbusy), .m1_wbusy(f_m1_wbusy),
    .s_addr(f_s_addr), .s_wdata(f_s_wdata), .s_wmask(f_s_wmask), .s_rstrb(f_s_rstrb),
    .s_rdata(f_s_rdata), .s_rbusy(f_s_rbusy), .s_wbusy(f_s_wbusy)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    m0_addr = '0; m0_wdata = 32'h0; m0_wmask = 4'h0; m0_rstrb = 1'b0;
    m1_addr = '0; m1_wdata = 32'h0; m1_wmask = 4'h0; m1_rstrb = 1'b0;
    f_m0_addr = '0; f_m0_wdata = 32'h0; f_m0_wmask = 4'h0; f_m0_rstrb = 1'b0;
    f_m1_addr = '0; f_m1_wdata = 32'h0; f_m1_wmask = 4'h0; f_m1_rstrb = 1'b0;
    s_rbusy = 1'b0; s_wbusy = 1'b0;
    tick; tick;
    checks++; if ({m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy} !== 4'b0000) begin failures++; $display("FAIL rst_busy got=%b exp=0000", {m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy}); end
    checks++; if ({s_rstrb, s_wmask} !== 5'b00000) begin failures++; $display("FAIL rst_strobes got=%b exp=00000", {s_rstrb, s_wmask}); end
    checks++; if (s_addr !== 24'h000000 || s_wdata !== 32'h0) begin failures++; $display("FAIL rst_sbus got=%0h/%0h exp=0/0", s_addr, s_wdata); end
    checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%0h/%0h exp=0/0", m0_rdata, m1_rdata); end
    reset = 1'b0;
    tick;
  endtask

  // Both masters read in the same cycle; m1_first selects the expected winner.
  task automatic test_tie(input logic m1_first);
    logic [AW-1:0] fa, sa;
    logic [31:0]   rd;
    fa = m1_first ? 24'h000300 : 24'h000200;
    sa = m1_first ? 24'h000200 : 24'h000300;
    m0_addr = 24'h000200; m1_addr = 24'h000300; m0_rstrb = 1'b1; m1_rstrb = 1'b1;
    tick; // T1
    m0_rstrb = 1'b0; m1_rstrb = 1'b0;
    checks++; if (s_rstrb !== 1'b1 || s_addr !== fa) begin failures++; $display("FAIL tie_first got=%b/%0h exp=1/%0h", s_rstrb, s_addr, fa); end
    checks++; if ({m0_rbusy, m1_rbusy} !== 2'b11) begin failures++; $display("FAIL tie_busy got=%b exp=11", {m0_rbusy, m1_rbusy}); end
    tick; // T2
    checks++; if (s_rstrb !== 1'b0) begin failures++; $display("FAIL tie_wait_rstrb got=%b exp=0", s_rstrb); end
    tick; // T3
    checks++; if (s_rstrb !== 1'b1 || s_addr !== sa) begin failures++; $display("FAIL tie_second got=%b/%0h exp=1/%0h", s_rstrb, s_addr, sa); end
    rd = m1_first ? m1_rdata : m0_rdata;
    checks++; if (rd !== {8'h5A, fa}) begin failures++; $display("FAIL tie_first_rdata got=%0h exp=%0h", rd, {8'h5A, fa}); end
    tick; tick; // T5
    rd = m1_first ? m0_rdata : m1_rdata;
    checks++; if (rd !== {8'h5A, sa}) begin failures++; $display("FAIL tie_second_rdata got=%0h exp=%0h", rd, {8'h5A, sa}); end
    checks++; if ({m0_rbusy, m1_rbusy} !== 2'b00) begin failures++; $display("FAIL tie_done_busy got=%b exp=00", {m0_rbusy, m1_rbusy}); end
  endtask

  task automatic test_read;
    m0_addr = 24'h000100; m0_rstrb = 1'b1;
    tick; // T1
    m0_rstrb = 1'b0;
    checks++; if (s_rstrb !== 1'b1 || s_addr !== 24'h000100 || s_wmask !== 4'h0) begin failures++; $display("FAIL rd_issue got=%b/%0h/%b exp=1/100/0000", s_rstrb, s_addr, s_wmask); end
    checks++; if (m0_rbusy !== 1'b1 || m0_wbusy !== 1'b0) begin failures++; $display("FAIL rd_busy_t1 got=%b%b exp=10", m0_rbusy, m0_wbusy); end
    tick; // T2
    checks++; if (m0_rbusy !== 1'b1 || s_rstrb !== 1'b0) begin failures++; $display("FAIL rd_t2 got=%b/%b exp=1/0", m0_rbusy, s_rstrb); end
    tick; // T3
    checks++; if (m0_rbusy !== 1'b0) begin failures++; $display("FAIL rd_busy_t3 got=%b exp=0", m0_rbusy); end
    checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data got=%0h exp=deadbeef", m0_rdata); end
  endtask

  task automatic test_write;
    m1_addr = 24'h000400; m1_wdata = 32'h00AB_0000; m1_wmask = 4'b0100;
    tick; // T1
    m1_wmask = 4'b0000;
    checks++; if (s_wmask !== 4'b0100 || s_wdata !== 32'h00AB_0000 || s_addr !== 24'h000400 || s_rstrb !== 1'b0) begin failures++; $display("FAIL wr_issue got=%b/%0h/%0h/%b exp=0100/ab0000/400/0", s_wmask, s_wdata, s_addr, s_rstrb); end
    checks++; if (m1_wbusy !== 1'b1 || m1_rbusy !== 1'b0) begin failures++; $display("FAIL wr_busy_t1 got=%b%b exp=10", m1_wbusy, m1_rbusy); end
    s_wbusy = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      tick;
      checks++; if (s_wmask !== 4'b0000 || m1_wbusy !== 1'b1) begin failures++; $display("FAIL wr_hold_t%0d got=%b/%b exp=0000/1", c, s_wmask, m1_wbusy); end
      if (c == 4) s_wbusy = 1'b0;
    end
    tick; // T5
    checks++; if (m1_wbusy !== 1'b0) begin failures++; $display("FAIL wr_busy_fall got=%b exp=0", m1_wbusy); end
    checks++; if (m1_rdata !== {8'h5A, 24'h000300}) begin failures++; $display("FAIL wr_rdata_hold got=%0h exp=5a000300", m1_rdata); end
  endtask

  task automatic test_read_and_write;
    m0_addr = 24'h000500; m0_wdata = 32'h1234_5678; m0_wmask = 4'hF; m0_rstrb = 1'b1;
    tick; // T1
    m0_wmask = 4'h0; m0_rstrb = 1'b0;
    checks++; if (s_rstrb !== 1'b1 || s_wmask !== 4'h0) begin failures++; $display("FAIL rw_strobes got=%b/%b exp=1/0000", s_rstrb, s_wmask); end
    checks++; if (m0_rbusy !== 1'b1 || m0_wbusy !== 1'b0) begin failures++; $display("FAIL rw_busy got=%b%b exp=10", m0_rbusy, m0_wbusy); end
    tick; tick; // T3
    checks++; if (m0_rdata !== 32'h5A00_0500 || m0_rbusy !== 1'b0 || m0_wbusy !== 1'b0) begin failures++; $display("FAIL rw_done got=%0h/%b%b exp=5a000500/00", m0_rdata, m0_rbusy, m0_wbusy); end
  endtask

  task automatic test_reset_mid_access;
    m0_addr = 24'h000600; m0_rstrb = 1'b1;
    tick; // T1
    m0_rstrb = 1'b0; s_rbusy = 1'b1;
    checks++; if (s_rstrb !== 1'b1) begin failures++; $display("FAIL rm_issue got=%b exp=1", s_rstrb); end
    tick; // T2, waiting on slave
    checks++; if (m0_rbusy !== 1'b1) begin failures++; $display("FAIL rm_wait got=%b exp=1", m0_rbusy); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy, s_rstrb, s_wmask} !== 9'b0) begin failures++; $display("FAIL rm_async got=%b exp=000000000", {m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy, s_rstrb, s_wmask}); end
    tick; tick;
    reset = 1'b0; s_rbusy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick;
      checks++; if (m0_rdata !== 32'h0 || m0_rbusy !== 1'b0 || s_rstrb !== 1'b0) begin failures++; $display("FAIL rm_after%0d got=%0h/%b/%b exp=0/0/0", c, m0_rdata, m0_rbusy, s_rstrb); end
    end
  endtask

  // m0 re-requests as soon as it is free; ties always go to m0.
  task automatic test_fixed_priority;
    logic [AW-1:0] a0, a1, a0b;
    for (int i = 0; i < 10; i++) begin
      a0  = 24'h001000 + 24'(i * 16);
      a1  = 24'h002000 + 24'(i * 16);
      a0b = 24'h003000 + 24'(i * 16);
      f_m0_addr = a0; f_m1_addr = a1; f_m0_rstrb = 1'b1; f_m1_rstrb = 1'b1;
      tick; // T1
      f_m0_rstrb = 1'b0; f_m1_rstrb = 1'b0;
      checks++; if (f_s_rstrb !== 1'b1 || f_s_addr !== a0) begin failures++; $display("FAIL fp_tie%0d got=%b/%0h exp=1/%0h", i, f_s_rstrb, f_s_addr, a0); end
      tick; tick; // T3
      checks++; if (f_m0_rbusy !== 1'b0 || f_m0_rdata !== {8'hC0, a0}) begin failures++; $display("FAIL fp_rd_a%0d got=%b/%0h exp=0/%0h", i, f_m0_rbusy, f_m0_rdata, {8'hC0, a0}); end
      checks++; if (f_s_addr !== a1) begin failures++; $display("FAIL fp_m1_slot%0d got=%0h exp=%0h", i, f_s_addr, a1); end
      f_m0_addr = a0b; f_m0_rstrb = 1'b1;
      tick; // T4
      f_m0_rstrb = 1'b0;
      tick; // T5
      checks++; if (f_s_rstrb !== 1'b1 || f_s_addr !== a0b) begin failures++; $display("FAIL fp_restrobe%0d got=%b/%0h exp=1/%0h", i, f_s_rstrb, f_s_addr, a0b); end
      checks++; if (f_m1_rdata !== {8'hC0, a1}) begin failures++; $display("FAIL fp_m1_data%0d got=%0h exp=%0h", i, f_m1_rdata, {8'hC0, a1}); end
      tick; tick; // T7
      checks++; if (f_m0_rbusy !== 1'b0 || f_m0_rdata !== {8'hC0, a0b}) begin failures++; $display("FAIL fp_rd_b%0d got=%b/%0h exp=0/%0h", i, f_m0_rbusy, f_m0_rdata, {8'hC0, a0b}); end
    end
  endtask

  initial begin
    test_reset();
    test_tie(1'b0);
    test_read();
    test_tie(1'b1);
    test_write();
    test_read_and_write();
    test_reset_mid_access();
    test_fixed_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
